// File: rtl/shifting_row_ctrl.sv
// shifting_row_ctrl: sequences one shifting_row (in_valid/in_data/in_ready in, shift_en/shift_data to row, row_valid/row_ready handshake, flush_req/busy zero-flush, fill_count)
module shifting_row_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ROW_WIDTH = 5,
  parameter int CNT_W = $clog2(ROW_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  flush_req,
  input  logic                  row_ready,
  output logic                  shift_en,
  output logic [DATA_WIDTH-1:0] shift_data,
  output logic                  row_valid,
  output logic [CNT_W-1:0]      fill_count,
  output logic                  busy
);
  localparam logic [1:0] FILL = 2'd0, FULL = 2'd1, FLUSH = 2'd2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROW_WIDTH - 1);
  logic [1:0] state;
  logic [CNT_W-1:0] fl_cnt;
  logic accept;
  assign in_ready = state == FILL && !flush_req;
  assign accept = in_valid && in_ready;
  assign busy = state == FLUSH;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      shift_en <= 1'b0;
      shift_data <= '0;
      row_valid <= 1'b0;
      fill_count <= '0;
      fl_cnt <= '0;
    end else begin
      shift_en <= accept;
      if (accept) shift_data <= in_data;
      if (state != FLUSH && flush_req) begin
        state <= FLUSH;
        shift_en <= 1'b1;
        shift_data <= '0;
        fl_cnt <= '0;
        fill_count <= '0;
        row_valid <= 1'b0;
      end else begin
        case (state)
          FILL: if (accept) begin
            fill_count <= fill_count + CNT_W'(1);
            if (fill_count == LAST) state <= FULL;
          end
          FULL: if (row_ready && row_valid) begin
            state <= FILL;
            row_valid <= 1'b0;
            fill_count <= '0;
          end else row_valid <= 1'b1;
          default: begin
            shift_en <= fl_cnt != LAST;
            shift_data <= '0;
            fl_cnt <= fl_cnt + CNT_W'(1);
            if (fl_cnt == LAST) state <= FILL;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_shifting_row_ctrl.sv
// tb_shifting_row_ctrl: table vectors, directed corner sequences and random traffic against a reference model
module tb_shifting_row_ctrl;
  localparam int DW = 8;
  localparam int RW = 5;
  localparam int CW = $clog2(RW + 1);
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, flush_req, row_ready, shift_en, row_valid, busy;
  logic [DW-1:0] in_data, shift_data;
  logic [CW-1:0] fill_count;
  int vec = 0;
  int bad = 0;
  bit chk_on = 0;
  shifting_row_ctrl #(.DATA_WIDTH(DW), .ROW_WIDTH(RW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .flush_req(flush_req), .row_ready(row_ready), .shift_en(shift_en), .shift_data(shift_data),
    .row_valid(row_valid), .fill_count(fill_count), .busy(busy)
  );
  always #5 clk = ~clk;
  logic [DW-1:0] row [RW];
  always @(posedge clk) if (shift_en) begin
    for (int i = RW - 1; i > 0; i--) row[i] <= row[i-1];
    row[0] <= shift_data;
  end
  function automatic logic [RW*DW-1:0] pack(input logic [DW-1:0] r [RW]);
    logic [RW*DW-1:0] p = '0;
    for (int i = 0; i < RW; i++) p[i*DW +: DW] = r[i];
    return p;
  endfunction
  int m_cnt = 0, m_fl = 0;
  bit m_rv = 0, m_se = 0;
  logic [DW-1:0] m_sd = '0;
  logic [DW-1:0] m_row [RW];
  bit c_rst, c_iv, c_fr, c_rr;
  logic [DW-1:0] c_id;
  function automatic bit m_ready(input bit fr);
    return m_fl == 0 && m_cnt < RW && !fr;
  endfunction
  function automatic void chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endfunction
  task automatic apply(input bit r, input bit iv, input logic [DW-1:0] id, input bit fr, input bit rr);
    c_rst = r; c_iv = iv; c_id = id; c_fr = fr; c_rr = rr;
    rst = r; in_valid = iv; in_data = id; flush_req = fr; row_ready = rr;
    @(negedge clk);
    if (chk_on) begin
      chk("in_ready", in_ready, m_ready(fr));
      chk("shift_en", shift_en, m_se);
      chk("shift_data", shift_data, m_sd);
      chk("row_valid", row_valid, m_rv);
      chk("fill_count", fill_count, m_cnt);
      chk("busy", busy, m_fl > 0);
      chk("row", pack(row), pack(m_row));
    end
  endtask
  task automatic tick();
    bit acc;
    acc = c_iv && m_ready(c_fr);
    @(posedge clk);
    if (m_se) begin
      for (int i = RW - 1; i > 0; i--) m_row[i] = m_row[i-1];
      m_row[0] = m_sd;
    end
    if (c_rst) begin
      m_cnt = 0; m_fl = 0; m_rv = 0; m_se = 0; m_sd = '0;
    end else begin
      if (m_fl > 0) m_fl--;
      else if (c_fr) begin m_fl = RW; m_cnt = 0; m_rv = 0; end
      else if (m_cnt == RW) begin
        if (c_rr && m_rv) begin m_cnt = 0; m_rv = 0; end else m_rv = 1;
      end else if (acc) m_cnt++;
      m_se = acc || m_fl > 0;
      if (acc) m_sd = c_id; else if (m_fl > 0) m_sd = '0;
    end
    #1;
  endtask
  task automatic step(input bit r, input bit iv, input logic [DW-1:0] id, input bit fr, input bit rr);
    apply(r, iv, id, fr, rr);
    tick();
  endtask
  typedef struct {
    bit iv; logic [DW-1:0] id; bit fr; bit rr;
    bit e_rdy; bit e_se; logic [DW-1:0] e_sd; bit e_rv; int e_fc; bit e_busy;
  } vec_t;
  vec_t tbl [18];
  int guard;
  initial begin
    tbl[0]  = '{1, 8'h11, 0, 0, 1, 0, 8'h00, 0, 0, 0};
    tbl[1]  = '{1, 8'h22, 0, 0, 1, 1, 8'h11, 0, 1, 0};
    tbl[2]  = '{1, 8'h33, 0, 0, 1, 1, 8'h22, 0, 2, 0};
    tbl[3]  = '{1, 8'h44, 0, 0, 1, 1, 8'h33, 0, 3, 0};
    tbl[4]  = '{1, 8'h55, 0, 0, 1, 1, 8'h44, 0, 4, 0};
    tbl[5]  = '{1, 8'h66, 0, 0, 0, 1, 8'h55, 0, 5, 0};
    tbl[6]  = '{1, 8'h66, 0, 0, 0, 0, 8'h55, 1, 5, 0};
    tbl[7]  = '{1, 8'h66, 0, 1, 0, 0, 8'h55, 1, 5, 0};
    tbl[8]  = '{1, 8'h77, 0, 0, 1, 0, 8'h55, 0, 0, 0};
    tbl[9]  = '{0, 8'h00, 0, 0, 1, 1, 8'h77, 0, 1, 0};
    tbl[10] = '{1, 8'h88, 1, 0, 0, 0, 8'h77, 0, 1, 0};
    tbl[11] = '{0, 8'h00, 1, 0, 0, 1, 8'h00, 0, 0, 1};
    tbl[12] = '{0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 1};
    tbl[13] = '{0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 1};
    tbl[14] = '{0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 1};
    tbl[15] = '{0, 8'h00, 0, 0, 0, 1, 8'h00, 0, 0, 1};
    tbl[16] = '{1, 8'h99, 0, 0, 1, 0, 8'h00, 0, 0, 0};
    tbl[17] = '{0, 8'h00, 0, 0, 1, 1, 8'h99, 0, 1, 0};
    for (int i = 0; i < RW; i++) begin row[i] = '0; m_row[i] = '0; end
    step(1, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    chk_on = 1;
    for (int i = 0; i < 18; i++) begin
      apply(0, tbl[i].iv, tbl[i].id, tbl[i].fr, tbl[i].rr);
      chk($sformatf("tbl%0d_rdy", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_se", i), shift_en, tbl[i].e_se);
      chk($sformatf("tbl%0d_sd", i), shift_data, tbl[i].e_sd);
      chk($sformatf("tbl%0d_rv", i), row_valid, tbl[i].e_rv);
      chk($sformatf("tbl%0d_fc", i), fill_count, tbl[i].e_fc);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      if (i == 6) chk("row_full", pack(row), 40'h1122334455);
      if (i == 16) chk("row_flushed", pack(row), 40'h0);
      tick();
    end
    for (int i = 0; i < 4; i++) step(0, 1, 8'hB0 + 8'(i), 0, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 8'hC0, 0, 0);
    step(0, 1, 8'hC1, 0, 1);
    step(0, 1, 8'hC2, 0, 0);
    step(0, 0, '0, 1, 0);
    for (int i = 0; i < RW + 1; i++) step(0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 8'hA0 + 8'(i), 0, 0);
      step(0, 0, 'x, 0, 0);
      step(0, 0, 'x, 0, 0);
    end
    step(0, 1, 8'hA3, 0, 0);
    step(0, 1, 8'hA4, 0, 0);
    guard = 0;
    while (!row_valid && guard < 10) begin step(0, 0, '0, 0, 0); guard++; end
    chk("row_valid_timeout", row_valid, 1'b1);
    step(0, 1, 8'hD0, 1, 1);
    step(0, 0, '0, 1, 0);
    for (int i = 0; i < RW + 1; i++) step(0, 0, '0, 0, 0);
    step(0, 1, 8'hE0, 0, 0);
    step(0, 0, '0, 1, 0);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    step(1, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, DW'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 3);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
